pipe_unscale: RTL

//   Inverse of the coefficient-scaling pipe stage. Takes a pair of scaled 16-bit samples plus
//   the 2-bit coefficient used to scale them, and recovers floor(data/cf) and remainder per lane.

---
 rtl/pipe_unscale.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipe_unscale.sv
// Return-path inverse of the coefficient-scaling stage: recovers floor(data/cf) and remainder
// for two lanes, with a single-cycle fast path for cf 0..2 and an iterative divider for cf==3.
module pipe_unscale #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       i_cf,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data0,
  input  logic [WIDTH-1:0] i_data1,
  output logic             o_rdy,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic [WIDTH-1:0] o_data0,
  output logic [WIDTH-1:0] o_data1,
  output logic [1:0]       o_rem0,
  output logic [1:0]       o_rem1,
  output logic             o_err
);

  // state | meaning
  // IDLE  | waiting for a transfer, o_rdy=1
  // FAST  | cf 0..2: result formed from latched operands in one cycle
  // DIV   | cf==3: restoring divide, one quotient bit per cycle, WIDTH cycles
  // DONE  | result presented, o_vld=1 until i_rdy
  typedef enum logic [1:0] {IDLE, FAST, DIV, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [1:0]       cf_q;
  logic [WIDTH-1:0] a0, a1;
  logic [WIDTH-1:0] q0, q1;
  logic [1:0]       r0, r1;
  logic             accept;
  logic [2:0]       s0, s1;
  logic [WIDTH+1:0] f0, f1;

  function automatic logic is_special(input logic [WIDTH-1:0] d);
    return (d == '0) || (d == '1);
  endfunction

  // Shift the next dividend bit into the partial remainder and trial-subtract 3.
  // Returns {quotient_bit, new_remainder}.
  function automatic logic [2:0] div_step(input logic [1:0] r, input logic b);
    logic [2:0] t;
    t = {r, b};
    if (t >= 3'd3) return {1'b1, 2'(t - 3'd3)};
    else           return {1'b0, t[1:0]};
  endfunction

  function automatic logic [WIDTH+1:0] fast_lane(input logic [WIDTH-1:0] d,
                                                 input logic [1:0] cf);
    if (is_special(d))    return {d, 2'b00};
    else if (cf == 2'd2)  return {1'b0, d[WIDTH-1:1], 1'b0, d[0]};
    else                  return {d, 2'b00};
  endfunction

  assign accept = i_en && o_rdy;
  assign o_rdy  = rst_n && (state == IDLE);
  assign o_vld  = (state == DONE);
  assign s0     = div_step(r0, q0[WIDTH-1]);
  assign s1     = div_step(r1, q1[WIDTH-1]);
  assign f0     = fast_lane(a0, cf_q);
  assign f1     = fast_lane(a1, cf_q);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (i_cf == 2'd3) ? DIV : FAST;
      FAST: state_nx = DONE;
      DIV:  if (cnt == '0) state_nx = DONE;
      DONE: if (i_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cf_q    <= '0;
      a0      <= '0;
      a1      <= '0;
      q0      <= '0;
      q1      <= '0;
      r0      <= '0;
      r1      <= '0;
      o_data0 <= '0;
      o_data1 <= '0;
      o_rem0  <= '0;
      o_rem1  <= '0;
      o_err   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            a0   <= i_data0;
            a1   <= i_data1;
            q0   <= i_data0;
            q1   <= i_data1;
            r0   <= '0;
            r1   <= '0;
            cf_q <= i_cf;
            cnt  <= CW'(WIDTH);
          end
        end
        FAST: begin
          {o_data0, o_rem0} <= f0;
          {o_data1, o_rem1} <= f1;
          o_err             <= (cf_q == 2'd0);
        end
        DIV: begin
          if (cnt != '0) begin
            q0  <= {q0[WIDTH-2:0], s0[2]};
            r0  <= s0[1:0];
            q1  <= {q1[WIDTH-2:0], s1[2]};
            r1  <= s1[1:0];
            cnt <= cnt - 1'b1;
          end else begin
            // Both lanes always run the full count; special lanes are overridden here.
            o_data0 <= is_special(a0) ? a0 : q0;
            o_rem0  <= is_special(a0) ? 2'b00 : r0;
            o_data1 <= is_special(a1) ? a1 : q1;
            o_rem1  <= is_special(a1) ? 2'b00 : r1;
            o_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
